// File: rtl/design1_pkg.sv
// Shared types and helpers for the A9 byte-stream bit-reversal datapath.
package design1_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  // Mirror a byte: result bit i takes source bit DATA_W-1-i.
  function automatic byte_t bit_reverse(input byte_t b);
    byte_t r;
    r = 8'h00;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = b[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/design1_if.sv
// Byte-stream bundle: qualified input beat toward the core, result beat back out.
interface design1_if;
  import design1_pkg::*;

  byte_t in_tdata;
  logic  in_valid;
  byte_t out_tdata;
  logic  out_tvalid;

  modport slave (
    input  in_tdata,
    input  in_valid,
    output out_tdata,
    output out_tvalid
  );

  modport master (
    output in_tdata,
    output in_valid,
    input  out_tdata,
    input  out_tvalid
  );

endinterface

// File: rtl/bitrev8.sv
// Purely combinational 8-bit bit reversal placed between the two pipeline stages.
module bitrev8
  import design1_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  // Pure wiring permutation, no logic depth.
  always_comb begin
    dout = bit_reverse(din);
  end

endmodule

// File: rtl/design1_core.sv
// Two-stage reversal pipeline: S1 captures the beat, S2 holds the mirrored byte and drives out.
module design1_core
  import design1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  design1_if.slave   bus
);

  byte_t s1_data_q, s1_data_d;
  logic  s1_valid_q, s1_valid_d;
  byte_t s2_data_q, s2_data_d;
  logic  s2_valid_q, s2_valid_d;
  byte_t rev_s;

  bitrev8 u_bitrev8 (
    .din  (s1_data_q),
    .dout (rev_s)
  );

  // Next-state: data registers only load on a valid beat so the output byte holds across gaps.
  always_comb begin
    s1_valid_d = bus.in_valid;
    s1_data_d  = s1_data_q;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s2_data_q;
    if (bus.in_valid) begin
      s1_data_d = bus.in_tdata;
    end else begin
      s1_data_d = s1_data_q;
    end
    if (s1_valid_q) begin
      s2_data_d = rev_s;
    end else begin
      s2_data_d = s2_data_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= 8'h00;
      s1_valid_q <= 1'b0;
      s2_data_q  <= 8'h00;
      s2_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      s2_data_q  <= s2_data_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign bus.out_tdata  = s2_data_q;
  assign bus.out_tvalid = s2_valid_q;

endmodule

// File: rtl/design1_wrapper.sv
// Integration wrapper for the A9 bit-reversal stream; flat _0-suffixed ports map onto the core bundle.
module design1_wrapper
  import design1_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              ap_clk_0,
  input  logic              ap_rst_n_0,
  input  logic [DATA_W-1:0] input_r_TDATA_0,
  input  logic              last_0,
  output logic [DATA_W-1:0] output_r_TDATA_0,
  output logic              output_r_TVALID_0
);

  if (DATA_W != 8) begin : g_width_check
    $error("design1_wrapper: only DATA_W = 8 is supported");
  end

  design1_if u_bus ();

  // Only a solid 1 on last_0 qualifies a beat.
  assign u_bus.in_tdata = input_r_TDATA_0;
  assign u_bus.in_valid = (last_0 == 1'b1);

  design1_core u_core (
    .clk   (ap_clk_0),
    .rst_n (ap_rst_n_0),
    .bus   (u_bus.slave)
  );

  assign output_r_TDATA_0  = u_bus.out_tdata;
  assign output_r_TVALID_0 = u_bus.out_tvalid;

endmodule

// File: tb/tb_design1_wrapper.sv
// Scoreboard bench for design1_wrapper: directed beats push hand-computed results, a monitor checks them.
module tb_design1_wrapper;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk;
  logic rst_n;

  design1_if u_tb_bus ();

  design1_wrapper #(.DATA_W(8)) dut (
    .ap_clk_0          (clk),
    .ap_rst_n_0        (rst_n),
    .input_r_TDATA_0   (u_tb_bus.in_tdata),
    .last_0            (u_tb_bus.in_valid),
    .output_r_TDATA_0  (u_tb_bus.out_tdata),
    .output_r_TVALID_0 (u_tb_bus.out_tvalid)
  );

  exp_t       exp_q[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_exp = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Drive one input level at the falling edge; a qualified beat pushes its mirrored result.
  task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] expd);
    @(negedge clk);
    u_tb_bus.in_tdata = d;
    u_tb_bus.in_valid = v;
    if (v && rst_n) begin
      exp_t e;
      e.data = expd;
      e.due  = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        check("reset_valid", {31'b0, u_tb_bus.out_tvalid}, 32'd0);
        check("reset_data", {24'b0, u_tb_bus.out_tdata}, 32'd0);
        last_exp = 8'h00;
      end else if (u_tb_bus.out_tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", {24'b0, u_tb_bus.out_tdata}, {24'b0, e.data});
          check("out_latency", cyc, e.due);
          last_exp = e.data;
        end
      end else begin
        check("hold_data", {24'b0, u_tb_bus.out_tdata}, {24'b0, last_exp});
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          check("missing_valid", 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    u_tb_bus.in_tdata = 8'h55;
    u_tb_bus.in_valid = 1'b1;

    // Beat presented during reset must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    u_tb_bus.in_valid = 1'b0;

    drive(1'b1, 8'h16, 8'h68);
    drive(1'b1, 8'h01, 8'h80);
    drive(1'b1, 8'h80, 8'h01);
    drive(1'b1, 8'hF0, 8'h0F);
    drive(1'b1, 8'hAA, 8'h55);
    drive(1'b0, 8'hFF, 8'h00);
    drive(1'b0, 8'hFF, 8'h00);
    drive(1'b0, 8'hFF, 8'h00);
    drive(1'b0, 8'hFF, 8'h00);

    drive(1'b1, 8'h00, 8'h00);
    drive(1'b1, 8'hFF, 8'hFF);
    drive(1'b1, 8'h81, 8'h81);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);

    // Two beats in flight, then reset between edges.
    drive(1'b1, 8'h12, 8'h48);
    drive(1'b1, 8'h34, 8'h2C);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_valid", {31'b0, u_tb_bus.out_tvalid}, 32'd0);
    check("midreset_data", {24'b0, u_tb_bus.out_tdata}, 32'd0);
    u_tb_bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    drive(1'b1, 8'h0B, 8'hD0);
    drive(1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/design1_wrapper.md
# design1_wrapper

Top-level byte-stream processor for the A9 stream datapath. Each accepted 8-bit input beat is bit-reversed (bit i → bit 7−i) and emitted on an AXI-Stream-style output with a valid flag. For example, 0x16 (0001_0110) becomes 0x68 (ASCII "h"). It is the wrapper level the system integrates directly, so port names carry the `_0` instance suffix.

## Interface
- `DATA_W`, default 8: stream byte width. Only 8 is supported.
- `ap_clk_0`  in  1  single system clock; all state updates on the rising edge.
- `ap_rst_n_0`  in  1  reset; asynchronous, active-low.
- `input_r_TDATA_0`  in  8  input byte.
- `last_0`  in  1  beat qualifier; 1 = `input_r_TDATA_0` is a valid beat this cycle.
- `output_r_TDATA_0`  out  8  bit-reversed result.
- `output_r_TVALID_0`  out  1  1 = `output_r_TDATA_0` holds a fresh result this cycle.

## Operation
- Acceptance: a beat is accepted on every rising edge where `last_0` == 1. Any other value, including an undriven level, means no beat.
- No backpressure: there is no TREADY in either direction. Every accepted beat produces exactly one output beat.
- Transform: `out[i] = in[7−i]` for i = 0..7. No arithmetic, no carries, no width change.
- Pipeline, two register stages:
  - S1 captures the byte and a valid bit.
  - S2 holds the reversed byte and the valid bit, and drives the outputs.
- Data hold: when no beat is accepted, the S2 valid bit goes to 0 and `output_r_TDATA_0` holds its previous value.
- Continuous input: `last_0` held at 1 gives one output per cycle with `output_r_TVALID_0` continuously 1. The byte may change every cycle.
- No frame state: there is no state machine and no packet tracking. `last_0` only qualifies individual beats.

## Timing
- Reset: while `ap_rst_n_0` = 0, `output_r_TDATA_0` = 0x00 and `output_r_TVALID_0` = 0, and both S1 and S2 are cleared. All of this takes effect immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N appears on the outputs after edge N+1 and stays there until edge N+2.
- Throughput: one beat per cycle, with no bubbles.
- Reset mid-stream: in-flight beats in S1/S2 are discarded, and no output valid is produced for them after reset is released.
- First edge after release: the first rising edge after `ap_rst_n_0` rises may accept a beat normally.
- Simultaneous reset and beat: a beat presented during reset is ignored.

## Structure
- Shared package `design1_pkg`, containing:
  - `DATA_W` = 8;
  - the typedef `byte_t` = logic [7:0].
- Sub-module `bitrev8`: a purely combinational 8-bit bit-reversal, instantiated once between S1 and S2.
- Wrapper body: two pipeline registers and the valid bits.

## Test plan
- Reset values: hold `ap_rst_n_0` = 0 for 2 cycles → `output_r_TDATA_0` = 0x00 and `output_r_TVALID_0` = 0 throughout.
- Single beat: after release, drive 0x16 with `last_0` = 1 → output 0x68 with valid = 1 after edge N+1.
- Continuous stream: keep `last_0` = 1 and drive 0x01, 0x80, 0xF0, 0xAA on consecutive cycles → outputs 0x80, 0x01, 0x0F, 0x55 on consecutive cycles, with valid held at 1 and no gaps.
- Gated beats: drive `last_0` = 0 with data 0xFF → valid stays 0 and the data output holds its prior value.
- Mid-stream reset: assert `ap_rst_n_0` = 0 between clock edges with beats in flight → outputs go to 0x00/0 immediately, and no stale valid appears after release.
- Palindromes: inputs 0x00, 0xFF and 0x81 → outputs identical to the inputs.
